// File: rtl/fu_div_iter_pkg.sv
// fu_div_iter_pkg
//    Shared definitions for the iterative divide functional unit:
//    widths, iteration count, FSM state encoding and a conditional
//    absolute-value helper used by the datapath.
package fu_div_iter_pkg;

   localparam int XLEN      = 32;
   localparam int PRF_IDX_W = 6;
   localparam int ROB_ID_W  = 6;
   localparam int DIV_ITER  = 32;
   localparam int CNT_W     = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      WB_LO = 2'd2,
      WB_HI = 2'd3
   } div_state_e;

   // Two's-complement magnitude when en is set, else passthrough.
   // 0x80000000 maps to itself, which is what makes the signed
   // overflow case come out as quotient 0x80000000 / remainder 0.
   function automatic logic [XLEN-1:0] abs_if(input logic en, input logic [XLEN-1:0] v);
      return (en && v[XLEN-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/fu_div_iter_core.sv
// fu_div_iter_core
//    Restoring radix-2 divide datapath: magnitude conversion on start,
//    one quotient bit per step, sign fix-up and divide-by-zero override
//    on the way out.
// Ports:
//    clk        clock
//    rst        synchronous reset, active low
//    start      load operands and clear the iteration counter
//    step       perform one iteration this cycle
//    in_signed  operands are two's complement (DIV) vs unsigned (DIVU)
//    a, b       dividend, divisor
//    done       high on the step that produces the final quotient bit
//    q, r       signed-corrected quotient and remainder
module fu_div_iter_core
   import fu_div_iter_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            step,
   input  logic            in_signed,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] q,
   output logic [XLEN-1:0] r
);

   logic [XLEN-1:0]  rem_q;
   logic [XLEN-1:0]  dq_q;     // dividend shifts out the top, quotient shifts in the bottom
   logic [XLEN-1:0]  b_abs_q;
   logic [CNT_W-1:0] cnt_q;
   logic             neg_q_q;
   logic             neg_r_q;
   logic             b_zero_q;

   logic [XLEN:0]    rem_shift;
   logic [XLEN:0]    diff;
   logic             q_bit;

   // The remainder is always below |b|, so the trial difference's top bit
   // is a clean borrow indicator.
   always_comb begin
      rem_shift = {rem_q, dq_q[XLEN-1]};
      diff      = rem_shift - {1'b0, b_abs_q};
      q_bit     = ~diff[XLEN];
   end

   assign done = step && (cnt_q == CNT_W'(DIV_ITER - 1));

   // With b == 0 the restoring loop already leaves |a| in the remainder;
   // only the quotient needs forcing, since sign fix would otherwise flip it.
   assign q = b_zero_q ? {XLEN{1'b1}} : (neg_q_q ? -dq_q : dq_q);
   assign r = neg_r_q ? -rem_q : rem_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rem_q    <= '0;
         dq_q     <= '0;
         b_abs_q  <= '0;
         cnt_q    <= '0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         b_zero_q <= 1'b0;
      end else if (start) begin
         rem_q    <= '0;
         dq_q     <= abs_if(in_signed, a);
         b_abs_q  <= abs_if(in_signed, b);
         cnt_q    <= '0;
         neg_q_q  <= in_signed && (a[XLEN-1] ^ b[XLEN-1]);
         neg_r_q  <= in_signed && a[XLEN-1];
         b_zero_q <= (b == '0);
      end else if (step) begin
         rem_q <= q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
         dq_q  <= {dq_q[XLEN-2:0], q_bit};
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/fu_div_iter.sv
// fu_div_iter
//    Iterative DIV/DIVU functional unit. Takes one op, spends 32 cycles
//    iterating, then emits the quotient (LO) and remainder (HI) as two
//    consecutive PRF write requests, finishing the ROB entry with the HI write.
// Ports:
//    clk, rst              clock; synchronous reset, active low
//    flush                 abort any op in flight, block issue this cycle
//    in_valid / in_ready   issue handshake
//    in_signed             DIV (1) or DIVU (0)
//    in_src_a, in_src_b    dividend, divisor
//    in_prd_lo, in_prd_hi  physical destinations for quotient / remainder
//    in_rob_id             ROB entry of the op
//    busy                  unit not idle
//    wb_wen/addr/data      PRF write request
//    fin_valid, fin_id     ROB finish
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for issue
// CALC  | 32 iterations, one quotient bit per cycle
// WB_LO | write quotient to prd_lo
// WB_HI | write remainder to prd_hi, finish ROB entry
module fu_div_iter
   import fu_div_iter_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_signed,
   input  logic [XLEN-1:0]      in_src_a,
   input  logic [XLEN-1:0]      in_src_b,
   input  logic [PRF_IDX_W-1:0] in_prd_lo,
   input  logic [PRF_IDX_W-1:0] in_prd_hi,
   input  logic [ROB_ID_W-1:0]  in_rob_id,
   output logic                 busy,
   output logic                 wb_wen,
   output logic [PRF_IDX_W-1:0] wb_addr,
   output logic [XLEN-1:0]      wb_data,
   output logic                 fin_valid,
   output logic [ROB_ID_W-1:0]  fin_id
);

   div_state_e           state;
   logic [PRF_IDX_W-1:0] prd_lo_q;
   logic [PRF_IDX_W-1:0] prd_hi_q;
   logic [ROB_ID_W-1:0]  rob_id_q;

   logic                 accept;
   logic                 core_step;
   logic                 core_done;
   logic [XLEN-1:0]      core_q;
   logic [XLEN-1:0]      core_r;

   // in_ready is held low while reset is asserted so nothing looks
   // acceptable until the reset is released.
   assign in_ready  = rst && (state == IDLE) && !flush;
   assign accept    = in_valid && in_ready;
   assign core_step = rst && !flush && (state == CALC);
   assign busy      = (state != IDLE);

   fu_div_iter_core u_core (
      .clk       (clk),
      .rst       (rst),
      .start     (accept),
      .step      (core_step),
      .in_signed (in_signed),
      .a         (in_src_a),
      .b         (in_src_b),
      .done      (core_done),
      .q         (core_q),
      .r         (core_r)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         prd_lo_q <= '0;
         prd_hi_q <= '0;
         rob_id_q <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state    <= CALC;
                  prd_lo_q <= in_prd_lo;
                  prd_hi_q <= in_prd_hi;
                  rob_id_q <= in_rob_id;
               end
            end
            CALC:    if (core_done) state <= WB_LO;
            WB_LO:   state <= WB_HI;
            WB_HI:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs depend only on state and held result/tag registers; flush
   // (and a reset arriving mid-cycle) suppress them.
   always_comb begin
      wb_wen    = 1'b0;
      wb_addr   = '0;
      wb_data   = '0;
      fin_valid = 1'b0;
      fin_id    = '0;
      if (rst && !flush) begin
         case (state)
            WB_LO: begin
               wb_wen  = 1'b1;
               wb_addr = prd_lo_q;
               wb_data = core_q;
            end
            WB_HI: begin
               wb_wen    = 1'b1;
               wb_addr   = prd_hi_q;
               wb_data   = core_r;
               fin_valid = 1'b1;
               fin_id    = rob_id_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fu_div_iter.sv
// tb_fu_div_iter
//    Directed bench for fu_div_iter. Each issued op pushes its two expected
//    write-backs (with the cycle they must appear in) onto a scoreboard; a
//    negedge monitor pops and compares every write-back the unit emits.
module tb_fu_div_iter;
   import fu_div_iter_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 flush;
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_signed;
   logic [XLEN-1:0]      in_src_a;
   logic [XLEN-1:0]      in_src_b;
   logic [PRF_IDX_W-1:0] in_prd_lo;
   logic [PRF_IDX_W-1:0] in_prd_hi;
   logic [ROB_ID_W-1:0]  in_rob_id;
   logic                 busy;
   logic                 wb_wen;
   logic [PRF_IDX_W-1:0] wb_addr;
   logic [XLEN-1:0]      wb_data;
   logic                 fin_valid;
   logic [ROB_ID_W-1:0]  fin_id;

   fu_div_iter dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_signed (in_signed),
      .in_src_a  (in_src_a),
      .in_src_b  (in_src_b),
      .in_prd_lo (in_prd_lo),
      .in_prd_hi (in_prd_hi),
      .in_rob_id (in_rob_id),
      .busy      (busy),
      .wb_wen    (wb_wen),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .fin_valid (fin_valid),
      .fin_id    (fin_id)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [5:0]  addr;
      logic [31:0] data;
      logic        fin;
      logic [5:0]  id;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (!s) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end
   endfunction

   task automatic push_exp(input int t, input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] lo, input logic [5:0] hi, input logic [5:0] id);
      logic [31:0] q, r;
      exp_t e;
      ref_div(s, a, b, q, r);
      e.cyc = t + 33; e.addr = lo; e.data = q; e.fin = 1'b0; e.id = 6'd0;
      sb.push_back(e);
      e.cyc = t + 34; e.addr = hi; e.data = r; e.fin = 1'b1; e.id = id;
      sb.push_back(e);
   endtask

   // Monitor: every write-back must match the head of the scoreboard.
   always @(negedge clk) begin
      if (wb_wen === 1'b1) begin
         if (sb.size() == 0) begin
            check("wb_unexpected", {63'd0, wb_wen}, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("wb_cycle",  cyc,       mon_e.cyc);
            check("wb_addr",   wb_addr,   mon_e.addr);
            check("wb_data",   wb_data,   mon_e.data);
            check("fin_valid", fin_valid, mon_e.fin);
            check("fin_id",    fin_id,    mon_e.id);
         end
      end else if (fin_valid !== 1'b0) begin
         check("fin_without_wb", {63'd0, fin_valid}, 64'd0);
      end
   end

   // Drives one op at a negedge, returns the accept cycle T.
   task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] lo, input logic [5:0] hi, input logic [5:0] id,
                        input bit expect_wb, output int t);
      @(negedge clk);
      in_valid  = 1'b1;
      in_signed = s;
      in_src_a  = a;
      in_src_b  = b;
      in_prd_lo = lo;
      in_prd_hi = hi;
      in_rob_id = id;
      #1;
      check("in_ready_at_issue", {63'd0, in_ready}, 64'd1);
      t = cyc;
      if (expect_wb) push_exp(t, s, a, b, lo, hi, id);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Waits for the scoreboard to empty, then checks the return to IDLE at T+35.
   task automatic drain(input int t, input string tag);
      int k = 0;
      while (sb.size() != 0 && k < 80) begin
         @(negedge clk);
         #1;
         k++;
      end
      check({tag, "_drained"}, sb.size(), 0);
      sb.delete();
      check({tag, "_last_wb_cycle"}, cyc, t + 34);
      check({tag, "_not_ready_in_wb_hi"}, {63'd0, in_ready}, 64'd0);
      @(negedge clk);
      #1;
      check({tag, "_ready_t35"}, {63'd0, in_ready}, 64'd1);
      check({tag, "_idle_t35"}, {63'd0, busy}, 64'd0);
   endtask

   task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] lo, input logic [5:0] hi, input logic [5:0] id,
                         input string tag);
      int t;
      issue(s, a, b, lo, hi, id, 1'b1, t);
      drain(t, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int t, ta, tb_acc, k;
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
      in_src_a = '0; in_src_b = '0; in_prd_lo = '0; in_prd_hi = '0; in_rob_id = '0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("rst_busy",     {63'd0, busy},     64'd0);
      check("rst_wb_wen",   {63'd0, wb_wen},   64'd0);
      check("rst_fin",      {63'd0, fin_valid},64'd0);
      check("rst_wb_data",  wb_data,           64'd0);
      rst = 1'b1;
      #1;
      check("ready_after_rst", {63'd0, in_ready}, 64'd1);

      // basic timing and the directed value cases
      run_op(1'b0, 32'd100,        32'd7,          6'd10, 6'd11, 6'd5,  "divu_100_7");
      run_op(1'b1, 32'hFFFF_FFF9,  32'd2,          6'd12, 6'd13, 6'd6,  "div_m7_2");
      run_op(1'b1, 32'd7,          32'hFFFF_FFFE,  6'd14, 6'd15, 6'd7,  "div_7_m2");
      run_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  6'd16, 6'd17, 6'd8,  "div_ovf");
      run_op(1'b0, 32'hFFFF_FFFF,  32'd1,          6'd18, 6'd19, 6'd9,  "divu_max_1");
      run_op(1'b0, 32'd5,          32'd0,          6'd20, 6'd21, 6'd10, "divu_5_0");
      run_op(1'b1, 32'hFFFF_FFFB,  32'd0,          6'd22, 6'd23, 6'd11, "div_m5_0");
      run_op(1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  6'd24, 6'd25, 6'd12, "div_m100_m7");
      for (int i = 0; i < 4; i++) begin
         run_op(i[0], $urandom, $urandom_range(1, 32'h0001_FFFF), 6'(30 + 2*i), 6'(31 + 2*i),
                6'(40 + i), "rand");
      end

      // flush in cycle T+10
      issue(1'b0, 32'd100, 32'd3, 6'd1, 6'd2, 6'd3, 1'b0, t);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      #1;
      check("flush_cyc",        cyc, t + 10);
      check("flush_ready_low",  {63'd0, in_ready}, 64'd0);
      check("flush_busy",       {63'd0, busy},     64'd1);
      @(posedge clk);
      #1;
      flush = 1'b0;
      #1;
      check("post_flush_idle",  {63'd0, busy},     64'd0);
      check("post_flush_ready", {63'd0, in_ready}, 64'd1);
      repeat (40) @(posedge clk);
      run_op(1'b0, 32'd9, 32'd3, 6'd4, 6'd5, 6'd6, "after_flush_9_3");

      // flush together with in_valid: request dropped
      @(negedge clk);
      in_valid = 1'b1; flush = 1'b1; in_signed = 1'b0;
      in_src_a = 32'd50; in_src_b = 32'd5;
      @(posedge clk);
      #1;
      in_valid = 1'b0; flush = 1'b0;
      #1;
      check("flush_drop_busy", {63'd0, busy}, 64'd0);
      repeat (40) @(posedge clk);

      // reset during CALC
      issue(1'b1, 32'd1000, 32'd7, 6'd7, 6'd8, 6'd9, 1'b0, t);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_busy",   {63'd0, busy},      64'd0);
      check("midrst_wen",    {63'd0, wb_wen},    64'd0);
      check("midrst_fin",    {63'd0, fin_valid}, 64'd0);
      check("midrst_ready",  {63'd0, in_ready},  64'd0);
      check("midrst_addr",   wb_addr,            64'd0);
      check("midrst_fin_id", fin_id,             64'd0);
      rst = 1'b1;
      #1;
      check("midrst_ready_after", {63'd0, in_ready}, 64'd1);
      repeat (40) @(posedge clk);

      // in_valid held high back-to-back
      @(negedge clk);
      in_valid = 1'b1; in_signed = 1'b0;
      in_src_a = 32'd1234; in_src_b = 32'd10;
      in_prd_lo = 6'd50; in_prd_hi = 6'd51; in_rob_id = 6'd20;
      #1;
      check("b2b_first_ready", {63'd0, in_ready}, 64'd1);
      ta = cyc;
      push_exp(ta, 1'b0, 32'd1234, 32'd10, 6'd50, 6'd51, 6'd20);
      @(posedge clk);
      #1;
      in_signed = 1'b1;
      in_src_a = 32'hFFFF_FC00; in_src_b = 32'd3;
      in_prd_lo = 6'd52; in_prd_hi = 6'd53; in_rob_id = 6'd21;
      k = 0;
      tb_acc = -1;
      while (k < 60) begin
         @(negedge clk);
         #1;
         k++;
         if (in_ready === 1'b1) begin
            tb_acc = cyc;
            break;
         end
      end
      check("b2b_spacing", tb_acc - ta, 35);
      push_exp(tb_acc, 1'b1, 32'hFFFF_FC00, 32'd3, 6'd52, 6'd53, 6'd21);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain(tb_acc, "b2b_second");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
